cia_timer_bank: RTL
===================

CIA_TIMER_BANK -- requirements
Module: cia_timer_bank

Interface
REQ-001 SHALL have parameter NUM_TIMERS, default 2, meaning number of timer channels (1..7).
REQ-002 SHALL have parameter TIMER_WIDTH, default 16, meaning counter/latch width in bits (8, 16, 24 or 32).
REQ-003 SHALL have ports: clk  in  1  system clock; res  in  1  reset. One clock; reset is synchronous and active-high.
REQ-004 SHALL have ports: phi2_p  in  1  tick strobe; phi2_n  in  1  bus strobe; cs_n  in  1  chip select, active low; rw  in  1  1=read.
REQ-005 SHALL have ports: rs  in  6  register select; db_in  in  8  write data; db_out  out  8  read data, registered.
REQ-006 SHALL have ports: cnt_in  in  1  external count input; tmr_out  out  NUM_TIMERS  per-timer pulse/toggle output; irq_n  out  1  interrupt, active low.

Function
REQ-007 SHALL perform register reads/writes only on clk cycles where phi2_n=1 and cs_n=0; all counting occurs only on phi2_p cycles ("ticks").
REQ-008 SHALL map timer i latch bytes at rs=4i+b (b=0 LSB); bytes at or above TIMER_WIDTH/8 SHALL read 0 and ignore writes; reads return the live counter byte.
REQ-009 SHALL map control register i at rs=0x20+i: [0] start, [1] output enable, [2] toggle mode, [3] one-shot, [4] force-load strobe, [6:5] input select, [7] reserved; bit 4 SHALL read 0.
REQ-010 SHALL map ICR/IMR at rs=0x28: read returns {~irq_n, flags}; write bit7=1 sets, bit7=0 clears mask bits given by db_in[NUM_TIMERS-1:0].
REQ-011 SHALL decode input select: 00 every tick; 01 cnt_in rising edge sampled at ticks; 10 underflow of timer i-1 in the same tick; 11 underflow of timer i-1 gated by cnt_in=1.
REQ-012 SHALL never count for timer 0 when input select is 10 or 11.
REQ-013 SHALL, on a tick with start=1 and count event, decrement the counter when nonzero, or, when zero, signal underflow, reload from latch, set flag i and toggle the toggle flip-flop; period is latch+1 events.
REQ-014 SHALL, on underflow with one-shot=1, clear start in the same tick.
REQ-015 SHALL, on a write to the top latch byte while start=0, copy the full latch into the counter immediately.
REQ-016 SHALL, on a write with bit 4 set, load counter from latch on the next tick and self-clear bit 4; if underflow occurs in that tick, force-load value wins and flag is still set.
REQ-017 SHALL, on a write setting start from 0 to 1, set the toggle flip-flop to 1.
REQ-018 SHALL drive tmr_out[i] on each tick: output enable=0 -> 0; toggle mode=1 -> toggle flip-flop; else 1 for exactly the underflow tick.
REQ-019 SHALL assert irq_n=0 at the tick after any (flags & mask) becomes nonzero and hold it until ICR read.
REQ-020 SHALL, on ICR read, clear all flags and release irq_n at the next tick; a flag set in that same tick SHALL survive and reassert irq_n one tick later if masked in.
REQ-021 SHALL, with latch=0 and continuous mode, underflow every count event.

Reset
REQ-022 SHALL, while res=1, set latches to all-ones, counters to 0, control, flags, mask and toggle flip-flops to 0, db_out=0x00, tmr_out=0, irq_n=1.
REQ-023 SHALL abort any count or pending force-load on reset mid-operation, with no flag or tmr_out pulse generated.

Configuration
REQ-024 SHALL, with CIA_TIMER_CASCADE_EN defined, implement input selects 10/11 per REQ-011.
REQ-025 SHALL, without CIA_TIMER_CASCADE_EN, treat input selects 10/11 as "never count" for every timer and read them back as written.

Verification
REQ-026 Latch timer0=0x0003, ctrl0=0x11 -> underflow every 4 ticks, flag0 set, tmr_out[0] off (enable=0).
REQ-027 Latch timer0=0x0002, ctrl0=0x19, IMR=0x81 -> one underflow after 3 ticks, start reads 0, irq_n low next tick, ICR read=0x81 then 0x00.
REQ-028 Cascade: timer0 latch=1 ctrl=0x11, timer1 latch=2 ctrl=0x51 -> timer1 underflows every 6 ticks; without macro timer1 never counts.
REQ-029 Toggle mode ctrl0=0x17, latch=0 -> tmr_out[0] toggles every tick, starting 1 after start.
REQ-030 ICR read on same tick as new underflow with mask set -> flag remains, irq_n high one tick then low again.

Source files
------------

// File: rtl/cia_timer_bank.sv
// cia_timer_bank: bank of CIA-style 16-bit-class down counters with reload
// latches, per-timer pulse/toggle outputs and a masked interrupt flag register.
// Ports: clk/res (sync, active-high); phi2_p tick strobe; phi2_n/cs_n/rw/rs
// bus cycle with db_in write data and registered db_out; cnt_in external
// count input; tmr_out per-timer output; irq_n active-low interrupt.
// Define CIA_TIMER_CASCADE_EN to enable timer-to-timer cascade input selects.
module cia_timer_bank #(
    parameter int NUM_TIMERS  = 2,
    parameter int TIMER_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  phi2_p,
    input  logic                  phi2_n,
    input  logic                  cs_n,
    input  logic                  rw,
    input  logic [5:0]            rs,
    input  logic [7:0]            db_in,
    output logic [7:0]            db_out,
    input  logic                  cnt_in,
    output logic [NUM_TIMERS-1:0] tmr_out,
    output logic                  irq_n
);
    localparam int NT = NUM_TIMERS;
    localparam int NB = TIMER_WIDTH / 8;
    localparam logic [TIMER_WIDTH-1:0] ONE = TIMER_WIDTH'(1);
`ifdef CIA_TIMER_CASCADE_EN
    localparam logic CASC = 1'b1;
`else
    localparam logic CASC = 1'b0;
`endif

    logic [NT-1:0][TIMER_WIDTH-1:0] latch;
    logic [NT-1:0][TIMER_WIDTH-1:0] cnt;
    logic [NT-1:0][TIMER_WIDTH-1:0] lat_nxt;
    logic [NT-1:0][1:0]             sel;
    logic [NT-1:0] start, oe, tog, os, force_ld, tff, flags, mask;
    logic [NT-1:0] ev, uf, top_wr;
    logic          cnt_prev;
    logic          wr_en, rd_en, icr_rd;
    logic [7:0]    rdata;
    logic [6:0]    flags7;

    assign wr_en  = phi2_n & ~cs_n & ~rw;
    assign rd_en  = phi2_n & ~cs_n & rw;
    assign icr_rd = rd_en & (rs == 6'h28);
    assign flags7 = 7'(flags);

    // Counter bytes read live; bytes beyond the timer width fall through to 0.
    always_comb begin
        rdata = 8'h00;
        for (int i = 0; i < NT; i++) begin
            for (int b = 0; b < NB; b++) begin
                if (rs == 6'(4 * i + b))
                    rdata = cnt[i][8*b +: 8];
            end
            if (rs == 6'(32 + i))
                rdata = {1'b0, sel[i], 1'b0, os[i], tog[i], oe[i], start[i]};
        end
        if (rs == 6'h28)
            rdata = {~irq_n, flags7};
    end

    // Latch with the byte being written merged in, so a top-byte write can
    // copy the complete new value into an idle counter in the same cycle.
    always_comb begin
        lat_nxt = latch;
        top_wr  = '0;
        for (int i = 0; i < NT; i++) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_en && rs == 6'(4 * i + b)) begin
                    lat_nxt[i][8*b +: 8] = db_in;
                    top_wr[i]            = (b == NB - 1);
                end
            end
        end
    end

    // Count events; cascade underflows ripple from timer i-1 within one tick.
    // Timer 0 has no predecessor, so its chain input is held at 0.
    always_comb begin
        logic up;
        up = 1'b0;
        ev = '0;
        uf = '0;
        for (int i = 0; i < NT; i++) begin
            case (sel[i])
                2'b00:   ev[i] = 1'b1;
                2'b01:   ev[i] = cnt_in & ~cnt_prev;
                2'b10:   ev[i] = CASC & up;
                default: ev[i] = CASC & up & cnt_in;
            endcase
            uf[i] = phi2_p & start[i] & ev[i] & (cnt[i] == '0);
            up    = uf[i];
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            latch    <= '1;
            cnt      <= '0;
            sel      <= '0;
            start    <= '0;
            oe       <= '0;
            tog      <= '0;
            os       <= '0;
            force_ld <= '0;
            tff      <= '0;
            flags    <= '0;
            mask     <= '0;
            cnt_prev <= 1'b0;
            db_out   <= 8'h00;
            tmr_out  <= '0;
            irq_n    <= 1'b1;
        end else begin
            if (phi2_p) begin
                cnt_prev <= cnt_in;
                // An ICR read in this tick releases irq for one tick even if
                // a new flag lands now; that flag reasserts on the next tick.
                irq_n    <= icr_rd | ~|(flags & mask);
                force_ld <= '0;
                for (int i = 0; i < NT; i++) begin
                    // Toggle mode shows the flip-flop as it entered the tick.
                    tmr_out[i] <= oe[i] & (tog[i] ? tff[i] : uf[i]);
                    if (force_ld[i] | uf[i])
                        cnt[i] <= latch[i];
                    else if (start[i] & ev[i])
                        cnt[i] <= cnt[i] - ONE;
                    if (uf[i]) begin
                        tff[i] <= ~tff[i];
                        if (os[i])
                            start[i] <= 1'b0;
                    end
                end
            end

            flags <= (icr_rd ? '0 : flags) | uf;
            latch <= lat_nxt;

            for (int i = 0; i < NT; i++) begin
                if (top_wr[i] & ~start[i])
                    cnt[i] <= lat_nxt[i];
                if (wr_en && rs == 6'(32 + i)) begin
                    start[i] <= db_in[0];
                    oe[i]    <= db_in[1];
                    tog[i]   <= db_in[2];
                    os[i]    <= db_in[3];
                    sel[i]   <= db_in[6:5];
                    if (db_in[4])
                        force_ld[i] <= 1'b1;
                    if (db_in[0] & ~start[i])
                        tff[i] <= 1'b1;
                end
            end

            if (wr_en && rs == 6'h28)
                mask <= db_in[7] ? (mask | db_in[NT-1:0])
                                 : (mask & ~db_in[NT-1:0]);

            if (rd_en)
                db_out <= rdata;
        end
    end

endmodule
